gyro_lookup_arbiter: RTL and testbench



---
 rtl/gyro_lookup_arbiter.sv | 151 +++++++++++++++
 tb/tb_gyro_lookup_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gyro_lookup_arbiter.sv
// gyro_lookup_arbiter: round-robin arbiter that lets three gyro axes share
// one lookup table, then folds the signed result back into +/-WRAP_HALF.
module gyro_lookup_arbiter #(
    parameter int LOOKUP_LATENCY = 4,
    parameter int WRAP_PASSES    = 4,
    parameter int WRAP_HALF      = 1440,
    parameter int WRAP_FULL      = 2880
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  req,
    input  logic [31:0] req_data_x,
    input  logic [31:0] req_data_y,
    input  logic [31:0] req_data_z,
    output logic [2:0]  ack,
    output logic [31:0] result,
    output logic [31:0] lookup_input,
    input  logic [31:0] lookup_output,
    output logic        busy
);

    localparam int CMAX = (LOOKUP_LATENCY > WRAP_PASSES) ?
                          LOOKUP_LATENCY : WRAP_PASSES;
    localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] LAT_LAST  = CW'(LOOKUP_LATENCY - 1);
    localparam logic [CW-1:0] WRAP_LAST = CW'(WRAP_PASSES - 1);
    localparam logic signed [31:0] HALF = 32'(WRAP_HALF);
    localparam logic signed [31:0] FULL = 32'(WRAP_FULL);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SIGN,
        WRAP,
        RESP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CW-1:0]      cnt_q;
    logic [1:0]         last_grant;
    logic [1:0]         chan_q;
    logic               sign_q;
    logic signed [31:0] temp_q;
    logic signed [31:0] wrapped;
    logic [1:0]         sel;
    logic [31:0]        sel_data;
    logic [31:0]        mag;

    // Search starts one past the last served channel.
    always_comb begin
        sel = 2'd0;
        unique case (last_grant)
            2'd0:    sel = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    sel = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: sel = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        sel_data = req_data_z;
        unique case (sel)
            2'd0:    sel_data = req_data_x;
            2'd1:    sel_data = req_data_y;
            default: sel_data = req_data_z;
        endcase
        mag = sel_data[31] ? -sel_data : sel_data;
    end

    always_comb begin
        wrapped = temp_q;
        if (temp_q > HALF) begin
            wrapped = temp_q - FULL;
        end else if (temp_q < -HALF) begin
            wrapped = temp_q + FULL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|req) state_d = WAIT;
            WAIT:    if (cnt_q == LAT_LAST) state_d = SIGN;
            SIGN:    state_d = WRAP;
            WRAP:    if (cnt_q == WRAP_LAST) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ack/result are loaded on the last WRAP edge so they are live in RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack          <= 3'b000;
            result       <= '0;
            lookup_input <= '0;
            cnt_q        <= '0;
            last_grant   <= 2'd2;
            chan_q       <= 2'd0;
            sign_q       <= 1'b0;
            temp_q       <= '0;
        end else begin
            ack <= 3'b000;
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        chan_q       <= sel;
                        sign_q       <= sel_data[31];
                        lookup_input <= mag;
                        cnt_q        <= '0;
                    end
                end
                WAIT: begin
                    cnt_q <= (cnt_q == LAT_LAST) ? '0 : cnt_q + 1'b1;
                end
                SIGN: begin
                    temp_q <= sign_q ? -$signed(lookup_output)
                                     : $signed(lookup_output);
                    cnt_q  <= '0;
                end
                WRAP: begin
                    temp_q <= wrapped;
                    if (cnt_q == WRAP_LAST) begin
                        result <= wrapped;
                        ack    <= 3'b001 << chan_q;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    last_grant <= chan_q;
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_gyro_lookup_arbiter.sv
// tb_gyro_lookup_arbiter: table vectors, hand sequences and random ops
// checked against a transaction-level reference of the arbiter.
module tb_gyro_lookup_arbiter;

    localparam int WP = 4;
    localparam longint WH = 1440;
    localparam longint WF = 2880;

    logic        clk;
    logic        reset_n;
    logic [2:0]  req;
    logic [31:0] req_data_x;
    logic [31:0] req_data_y;
    logic [31:0] req_data_z;
    logic [2:0]  ack;
    logic [31:0] result;
    logic [31:0] lookup_input;
    logic [31:0] lookup_output;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int last_g = 2;

    gyro_lookup_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .req_data_x    (req_data_x),
        .req_data_y    (req_data_y),
        .req_data_z    (req_data_z),
        .ack           (ack),
        .result        (result),
        .lookup_input  (lookup_input),
        .lookup_output (lookup_output),
        .busy          (busy)
    );

    assign lookup_output = lookup_input;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req;
        logic [31:0] dx;
        logic [31:0] dy;
        logic [31:0] dz;
        logic [2:0]  ack;
        logic [31:0] res;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            checks++;
            if ($countones(ack) > 1) begin
                errors++;
                $display("FAIL ack_onehot: got %b expected at most one bit",
                         ack);
            end
        end
    end

    function automatic logic [31:0] ref_result(input logic [31:0] d);
        longint t;
        t = longint'($signed(d));
        for (int i = 0; i < WP; i++) begin
            if (t > WH) t = t - WF;
            else if (t < -WH) t = t + WF;
        end
        return t[31:0];
    endfunction

    function automatic logic [31:0] ref_mag(input logic [31:0] d);
        longint t;
        t = longint'($signed(d));
        if (t < 0) t = -t;
        return t[31:0];
    endfunction

    function automatic int rr_pick(input int last, input logic [2:0] r);
        for (int i = 1; i <= 3; i++) begin
            if (r[(last + i) % 3]) return (last + i) % 3;
        end
        return last;
    endfunction

    function automatic logic [31:0] rand_data();
        int v;
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: begin
                v = int'($urandom_range(0, 12000)) - 6000;
                return v;
            end
            2: begin
                v = int'($urandom_range(0, 3));
                v = (v < 2) ? 1440 + v : -(1438 + v);
                return v;
            end
            default: return 32'h8000_0000;
        endcase
    endfunction

    // mode 0: hold inputs; 1: scramble req/data; 2: drop req, data_x = 7
    task automatic do_op(input logic [2:0] r, input logic [31:0] dx,
                         input logic [31:0] dy, input logic [31:0] dz,
                         input int ch, input logic [31:0] exp_res,
                         input int mode);
        logic [31:0] d;
        logic [31:0] m;
        logic [2:0]  onehot;
        d = (ch == 0) ? dx : ((ch == 1) ? dy : dz);
        m = ref_mag(d);
        onehot = 3'b001 << ch;
        @(negedge clk);
        req = r;
        req_data_x = dx;
        req_data_y = dy;
        req_data_z = dz;
        @(posedge clk);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k <= 4) check("lookup_input", lookup_input, m);
            check("busy_op", {31'd0, busy}, 32'd1);
            check("ack_early", {29'd0, ack}, 32'd0);
            if (mode == 1) begin
                req = 3'($urandom);
                req_data_x = $urandom;
                req_data_y = $urandom;
                req_data_z = $urandom;
            end else if (mode == 2 && k == 0) begin
                req = 3'b000;
                req_data_x = 32'd7;
            end
            @(posedge clk);
        end
        @(negedge clk);
        check("ack", {29'd0, ack}, {29'd0, onehot});
        check("result", result, exp_res);
        req = 3'b000;
        @(posedge clk);
        @(negedge clk);
        check("ack_after", {29'd0, ack}, 32'd0);
        check("busy_after", {31'd0, busy}, 32'd0);
        check("result_held", result, exp_res);
        last_g = ch;
    endtask

    initial begin
        int ch;
        int nacks;
        int prev;
        logic [2:0]  r;
        logic [31:0] dx;
        logic [31:0] dy;
        logic [31:0] dz;

        tbl[0] = '{3'b001, 32'd100, 32'd0, 32'd0, 3'b001, 32'd100};
        tbl[1] = '{3'b010, 32'd0, -32'sd500, 32'd0, 3'b010, -32'sd500};
        tbl[2] = '{3'b100, 32'd0, 32'd0, 32'd3000, 3'b100, 32'd120};
        tbl[3] = '{3'b001, -32'sd4400, 32'd0, 32'd0, 3'b001, 32'd1360};
        tbl[4] = '{3'b010, 32'd0, 32'd1440, 32'd0, 3'b010, 32'd1440};
        tbl[5] = '{3'b100, 32'd0, 32'd0, -32'sd1441, 3'b100, 32'd1439};
        tbl[6] = '{3'b001, 32'h8000_0000, 32'd0, 32'd0, 3'b001,
                   32'h8000_2D00};
        tbl[7] = '{3'b111, 32'd9, -32'sd2880, 32'd9, 3'b010, 32'd0};
        tbl[8] = '{3'b101, 32'd9, 32'd9, 32'd1441, 3'b100, -32'sd1439};
        tbl[9] = '{3'b011, 32'd5, 32'd8, 32'd9, 3'b001, 32'd5};

        reset_n = 1'b0;
        req = 3'b000;
        req_data_x = '0;
        req_data_y = '0;
        req_data_z = '0;
        repeat (2) @(negedge clk);
        check("rst_ack", {29'd0, ack}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_lookup", lookup_input, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            ch = tbl[i].ack[0] ? 0 : (tbl[i].ack[1] ? 1 : 2);
            do_op(tbl[i].req, tbl[i].dx, tbl[i].dy, tbl[i].dz,
                  ch, tbl[i].res, 0);
        end

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_ack", {29'd0, ack}, 32'd0);
            check("idle_result", result, 32'd5);
            check("idle_lookup", lookup_input, 32'd5);
        end

        do_op(3'b001, 32'd321, 32'd0, 32'd0, 0, 32'd321, 2);

        for (int i = 0; i < 40; i++) begin
            r = 3'($urandom_range(1, 7));
            dx = rand_data();
            dy = rand_data();
            dz = rand_data();
            ch = rr_pick(last_g, r);
            do_op(r, dx, dy, dz, ch,
                  ref_result((ch == 0) ? dx : ((ch == 1) ? dy : dz)), 1);
        end

        @(negedge clk);
        reset_n = 1'b0;
        req = 3'b111;
        req_data_x = 32'd10;
        req_data_y = 32'd20;
        req_data_z = 32'd30;
        last_g = 2;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        nacks = 0;
        prev = 0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (ack != 3'b000) begin
                if (nacks < 4) begin
                    ch = rr_pick(last_g, 3'b111);
                    check("rr_ack", {29'd0, ack}, 32'd1 << ch);
                    check("rr_spacing", n - prev, (nacks == 0) ? 10 : 11);
                    last_g = ch;
                    prev = n;
                end
                nacks++;
            end
        end
        check("rr_count", nacks, 32'd4);

        reset_n = 1'b0;
        req = 3'b000;
        last_g = 2;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        req = 3'b100;
        req_data_z = 32'd77;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("wait_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        req = 3'b000;
        #1;
        check("abort_ack", {29'd0, ack}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_lookup", lookup_input, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_ack", {29'd0, ack}, 32'd0);
        end
        reset_n = 1'b1;
        do_op(3'b101, 32'd55, 32'd0, 32'd66, 0, 32'd55, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
